read_bus_mux: RTL and testbench
===============================

// Module: read_bus_mux
// PURPOSE
//  Read-side counterpart of the FFT buffer write mux: steers the single RAM read port
//  to the FFT core (MODE_RUN_FFT) or the DMA readout engine (MODE_DMA).
//  Tags every issued read with its owner through a RAM_LAT-deep pipeline.
//  Returns each read datum and its valid strobe only to the requester that issued it,
//  even if the mode changes while the read is in flight.
// PARAMETERS
//  FFT_N             10  log2 FFT length; each RAM bank has 2^(FFT_N-1) words
//  FFT_DW            16  real/imag width; RAM word = FFT_DW*2
//  RAM_LAT           1   RAM read latency in clk cycles (>=1)
//  MODE_INPUT_STREAM 0   mode code
//  MODE_RUN_FFT      1   mode code
//  MODE_DMA          2   mode code
//  MODE_DISABLE      3   mode code
// PORTS
//  clk         in   1           clock; all state on rising edge
//  rst         in   1           synchronous, active-high reset
//  mode        in   2           current operating mode
//  ract_fft    in   1           FFT read request
//  ra_fft      in   FFT_N-1     FFT read address
//  rdr_fft     out  FFT_DW*2    FFT read data
//  rvalid_fft  out  1           rdr_fft valid strobe
//  ract_dma    in   1           DMA read request
//  ra_dma      in   FFT_N-1     DMA read address
//  rdr_dma     out  FFT_DW*2    DMA read data
//  rvalid_dma  out  1           rdr_dma valid strobe
//  ract_ram    out  1           RAM read enable
//  ra_ram      out  FFT_N-1     RAM read address
//  rdr_ram     in   FFT_DW*2    RAM read data, valid RAM_LAT cycles after ract_ram
//  busy        out  1           one or more reads in flight
//  rd_err      out  1           sticky: a request was dropped
// BEHAVIOUR
//  - Request mux is combinational:
//    - MODE_RUN_FFT: ract/ra_ram = fft inputs.
//    - MODE_DMA: ract/ra_ram = dma inputs.
//    - Other modes: ract_ram=0, ra_ram=0.
//  - Tag pipeline: RAM_LAT stages of {valid, owner}.
//    - Stage 0 loads {ract_ram, owner(mode)} each cycle.
//    - Each stage shifts every cycle; there is no stall. The RAM port is always ready.
//  - Return:
//    - When the last stage is valid, rvalid_<owner>=1 and rdr_<owner>=rdr_ram.
//    - The non-owner gets rvalid=0 and rdr=0.
//    - When no read returns, both rdr_*=0.
//  - Latency: ract_x at cycle t -> rvalid_x at cycle t+RAM_LAT. Throughput is 1 read/cycle.
//  - Mode change mid-flight:
//    - In-flight tags keep their original owner and are delivered to it.
//    - New requests follow the new mode from the same cycle.
//    - Reads issued before and after the switch can return on consecutive cycles to different owners.
//  - busy = OR of all tag valid bits. The controller must not leave MODE_DMA/RUN_FFT
//    for a mode that rewrites RAM until busy=0. The block does not enforce this.
//  - rd_err:
//    - Set when ract_fft=1 while mode!=MODE_RUN_FFT.
//    - Set when ract_dma=1 while mode!=MODE_DMA.
//    - Held until rst. Dropped requests issue nothing.
//  - Reset (also mid-operation): all tags cleared, so in-flight reads are discarded.
//    - rvalid_*=0, rdr_*=0, busy=0, rd_err=0 from the cycle after rst is sampled high.
//    - While rst=1, ract_ram=0.
// CONFIGURATION
//  READ_BUS_MUX_REG_OUT_EN:
//    - Defined: rvalid_*/rdr_* pass through one extra output register.
//      - Latency becomes RAM_LAT+1.
//      - busy also includes the output-register valid bit.
//      - The output register resets to 0.
//    - Undefined: outputs are combinational from the last tag stage and rdr_ram.
//      - Latency is RAM_LAT.
// TESTING (RAM model with RAM_LAT=1 unless stated; data = addr ^ 32'hA5A5_0000)
//  1. mode=1, ract_fft=1, ra_fft=0..7 on consecutive cycles
//     -> rvalid_fft on 8 consecutive cycles starting 1 cycle later
//     -> rdr_fft=32'hA5A5_0000..0007; rvalid_dma stays 0.
//  2. mode=2, DMA burst addr 0x1FF then 0x000 (wrap)
//     -> rdr_dma=32'hA5A5_01FF, then 32'hA5A5_0000; busy=1 exactly while in flight.
//  3. RAM_LAT=3: FFT read addr 5 at t, switch mode 1->2 at t+1, DMA read addr 6 at t+1
//     -> rvalid_fft with 32'hA5A5_0005 at t+3; rvalid_dma with 32'hA5A5_0006 at t+4.
//  4. mode=0 with ract_fft=1 -> ract_ram=0, no rvalid, rd_err=1 next cycle and held;
//     rst clears it.
//  5. rst asserted 1 cycle after a DMA read issue (RAM_LAT=2)
//     -> no rvalid_dma ever appears for that read; busy=0 after reset.
//  6. Rerun tests 1 and 3 with READ_BUS_MUX_REG_OUT_EN defined -> every rvalid is 1 cycle later;
//     data unchanged.

Source files
------------

// File: rtl/read_bus_mux.sv
// Steers the single RAM read port to the FFT core or DMA engine; returns each datum to its issuer.
// Optional macro READ_BUS_MUX_REG_OUT_EN adds one output register stage on rvalid_*/rdr_*.
module read_bus_mux #(
    parameter int unsigned FFT_N             = 10,
    parameter int unsigned FFT_DW            = 16,
    parameter int unsigned RAM_LAT           = 1,
    parameter logic [1:0]  MODE_INPUT_STREAM = 2'd0,
    parameter logic [1:0]  MODE_RUN_FFT      = 2'd1,
    parameter logic [1:0]  MODE_DMA          = 2'd2,
    parameter logic [1:0]  MODE_DISABLE      = 2'd3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic                  ract_fft,
    input  logic [FFT_N-2:0]      ra_fft,
    output logic [FFT_DW*2-1:0]   rdr_fft,
    output logic                  rvalid_fft,
    input  logic                  ract_dma,
    input  logic [FFT_N-2:0]      ra_dma,
    output logic [FFT_DW*2-1:0]   rdr_dma,
    output logic                  rvalid_dma,
    output logic                  ract_ram,
    output logic [FFT_N-2:0]      ra_ram,
    input  logic [FFT_DW*2-1:0]   rdr_ram,
    output logic                  busy,
    output logic                  rd_err
);

    localparam int unsigned DW = FFT_DW * 2;

    typedef enum logic {
        OwnFft,
        OwnDma
    } owner_e;

    typedef struct packed {
        logic   vld;
        owner_e own;
    } tag_t;

    owner_e req_owner;
    tag_t   tag_q [RAM_LAT];
    logic   drop;
    logic   rd_err_q;
    logic   tag_busy;
    logic   ret_fft_v, ret_dma_v;
    logic [DW-1:0] ret_fft_d, ret_dma_d;

    always_comb begin
        ract_ram  = 1'b0;
        ra_ram    = '0;
        req_owner = OwnFft;
        if (!rst) begin
            case (mode)
                MODE_RUN_FFT: begin
                    ract_ram = ract_fft;
                    ra_ram   = ra_fft;
                end
                MODE_DMA: begin
                    ract_ram  = ract_dma;
                    ra_ram    = ra_dma;
                    req_owner = OwnDma;
                end
                MODE_INPUT_STREAM, MODE_DISABLE: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Owner is captured at issue so a later mode change cannot misroute the return.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAM_LAT; i++) begin
                tag_q[i] <= '{vld: 1'b0, own: OwnFft};
            end
        end else begin
            tag_q[0] <= '{vld: ract_ram, own: req_owner};
            for (int i = 1; i < RAM_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_comb begin
        tag_busy = 1'b0;
        for (int i = 0; i < RAM_LAT; i++) begin
            tag_busy = tag_busy | tag_q[i].vld;
        end
    end

    always_comb begin
        ret_fft_v = tag_q[RAM_LAT-1].vld && (tag_q[RAM_LAT-1].own == OwnFft);
        ret_dma_v = tag_q[RAM_LAT-1].vld && (tag_q[RAM_LAT-1].own == OwnDma);
        ret_fft_d = ret_fft_v ? rdr_ram : '0;
        ret_dma_d = ret_dma_v ? rdr_ram : '0;
    end

    assign drop = (ract_fft && (mode != MODE_RUN_FFT)) || (ract_dma && (mode != MODE_DMA));

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_err_q <= 1'b0;
        end else if (drop) begin
            rd_err_q <= 1'b1;
        end
    end

    assign rd_err = rd_err_q;

`ifdef READ_BUS_MUX_REG_OUT_EN
    logic          out_fft_v_q, out_dma_v_q;
    logic [DW-1:0] out_fft_d_q, out_dma_d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_fft_v_q <= 1'b0;
            out_dma_v_q <= 1'b0;
            out_fft_d_q <= '0;
            out_dma_d_q <= '0;
        end else begin
            out_fft_v_q <= ret_fft_v;
            out_dma_v_q <= ret_dma_v;
            out_fft_d_q <= ret_fft_d;
            out_dma_d_q <= ret_dma_d;
        end
    end

    assign rvalid_fft = out_fft_v_q;
    assign rvalid_dma = out_dma_v_q;
    assign rdr_fft    = out_fft_d_q;
    assign rdr_dma    = out_dma_d_q;
    assign busy       = tag_busy | out_fft_v_q | out_dma_v_q;
`else
    assign rvalid_fft = ret_fft_v;
    assign rvalid_dma = ret_dma_v;
    assign rdr_fft    = ret_fft_d;
    assign rdr_dma    = ret_dma_d;
    assign busy       = tag_busy;
`endif

endmodule

// File: tb/tb_read_bus_mux.sv
// Scoreboard bench for read_bus_mux with a latency-LAT RAM model (data = addr ^ 32'hA5A5_0000).
// Honours READ_BUS_MUX_REG_OUT_EN by expecting one extra cycle of return latency.
module tb_read_bus_mux;

    localparam int unsigned LAT = 3;
`ifdef READ_BUS_MUX_REG_OUT_EN
    localparam int unsigned OUT_LAT = LAT + 1;
`else
    localparam int unsigned OUT_LAT = LAT;
`endif

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        ract_fft, ract_dma;
    logic [8:0]  ra_fft, ra_dma;
    logic [31:0] rdr_fft, rdr_dma, rdr_ram;
    logic        rvalid_fft, rvalid_dma;
    logic        ract_ram;
    logic [8:0]  ra_ram;
    logic        busy, rd_err;

    logic [31:0] ram_pipe [LAT];

    exp_t        q_fft[$];
    exp_t        q_dma[$];
    int unsigned cyc = 0;
    logic        err_m = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    read_bus_mux #(
        .FFT_N  (10),
        .FFT_DW (16),
        .RAM_LAT(LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .ract_fft  (ract_fft),
        .ra_fft    (ra_fft),
        .rdr_fft   (rdr_fft),
        .rvalid_fft(rvalid_fft),
        .ract_dma  (ract_dma),
        .ra_dma    (ra_dma),
        .rdr_dma   (rdr_dma),
        .rvalid_dma(rvalid_dma),
        .ract_ram  (ract_ram),
        .ra_ram    (ra_ram),
        .rdr_ram   (rdr_ram),
        .busy      (busy),
        .rd_err    (rd_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [8:0] a);
        return {23'd0, a} ^ 32'hA5A5_0000;
    endfunction

    // RAM: word for the address presented at cycle t appears during cycle t+LAT.
    always @(posedge clk) begin
        ram_pipe[0] <= ram_word(ra_ram);
        for (int i = 1; i < LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign rdr_ram = ram_pipe[LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: issue decisions from the current inputs at each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            while (q_fft.size() > 0 && q_fft[q_fft.size()-1].due > cyc) void'(q_fft.pop_back());
            while (q_dma.size() > 0 && q_dma[q_dma.size()-1].due > cyc) void'(q_dma.pop_back());
            err_m = 1'b0;
        end else begin
            if (mode == 2'd1 && ract_fft) q_fft.push_back('{cyc + OUT_LAT, ram_word(ra_fft)});
            if (mode == 2'd2 && ract_dma) q_dma.push_back('{cyc + OUT_LAT, ram_word(ra_dma)});
            if ((ract_fft && mode != 2'd1) || (ract_dma && mode != 2'd2)) err_m = 1'b1;
        end
        cyc = cyc + 1;
    end

    // Monitor: compare every output once per cycle, away from the active edge.
    always @(negedge clk) begin
        logic        e_v;
        logic [31:0] e_d;
        logic        e_busy;
        logic        e_ract;
        logic [8:0]  e_ra;
        if (cyc >= 1) begin
            e_busy = 1'b0;
            foreach (q_fft[j]) if (q_fft[j].due - OUT_LAT < cyc) e_busy = 1'b1;
            foreach (q_dma[j]) if (q_dma[j].due - OUT_LAT < cyc) e_busy = 1'b1;
            chk("busy", {31'd0, busy}, {31'd0, e_busy});
            chk("rd_err", {31'd0, rd_err}, {31'd0, err_m});

            e_ract = 1'b0;
            e_ra   = '0;
            if (!rst && mode == 2'd1) begin e_ract = ract_fft; e_ra = ra_fft; end
            if (!rst && mode == 2'd2) begin e_ract = ract_dma; e_ra = ra_dma; end
            chk("ract_ram", {31'd0, ract_ram}, {31'd0, e_ract});
            if (e_ract) chk("ra_ram", {23'd0, ra_ram}, {23'd0, e_ra});

            e_v = 1'b0;
            e_d = '0;
            if (q_fft.size() > 0 && q_fft[0].due == cyc) begin
                e_v = 1'b1;
                e_d = q_fft[0].data;
                void'(q_fft.pop_front());
            end
            chk("rvalid_fft", {31'd0, rvalid_fft}, {31'd0, e_v});
            chk("rdr_fft", rdr_fft, e_d);

            e_v = 1'b0;
            e_d = '0;
            if (q_dma.size() > 0 && q_dma[0].due == cyc) begin
                e_v = 1'b1;
                e_d = q_dma[0].data;
                void'(q_dma.pop_front());
            end
            chk("rvalid_dma", {31'd0, rvalid_dma}, {31'd0, e_v});
            chk("rdr_dma", rdr_dma, e_d);
        end
    end

    task automatic step(input logic r, input logic [1:0] m, input logic af,
                        input logic [8:0] aa, input logic ad, input logic [8:0] da);
        rst      = r;
        mode     = m;
        ract_fft = af;
        ra_fft   = aa;
        ract_dma = ad;
        ra_dma   = da;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [1:0] m, input int n);
        for (int i = 0; i < n; i++) step(1'b0, m, 1'b0, 9'd0, 1'b0, 9'd0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 1'b0, 9'd0, 1'b0, 9'd0);

        // FFT burst of 8 consecutive reads
        for (int a = 0; a < 8; a++) step(1'b0, 2'd1, 1'b1, 9'(a), 1'b0, 9'd0);
        idle(2'd1, LAT + 3);

        // DMA burst across the address wrap
        step(1'b0, 2'd2, 1'b0, 9'd0, 1'b1, 9'h1FF);
        step(1'b0, 2'd2, 1'b0, 9'd0, 1'b1, 9'h000);
        idle(2'd2, LAT + 3);

        // Mode switch with an FFT read still in flight
        step(1'b0, 2'd1, 1'b1, 9'd5, 1'b0, 9'd0);
        step(1'b0, 2'd2, 1'b0, 9'd0, 1'b1, 9'd6);
        idle(2'd2, LAT + 3);

        // Dropped request sets sticky error; reset clears it
        step(1'b0, 2'd0, 1'b1, 9'd3, 1'b0, 9'd0);
        idle(2'd0, 4);
        step(1'b1, 2'd0, 1'b0, 9'd0, 1'b0, 9'd0);
        idle(2'd0, 2);

        // Reset lands while a DMA read is in flight
        step(1'b0, 2'd2, 1'b0, 9'd0, 1'b1, 9'd77);
        step(1'b1, 2'd2, 1'b0, 9'd0, 1'b0, 9'd0);
        idle(2'd2, LAT + 3);

        // Randomized traffic with mode changes and occasional resets
        for (int i = 0; i < 400; i++) begin
            logic [1:0] m;
            m = (i % 7 == 0) ? 2'($urandom_range(0, 3)) : mode;
            step(($urandom_range(0, 59) == 0), m, 1'($urandom), 9'($urandom),
                 1'($urandom), 9'($urandom));
        end
        idle(2'd0, LAT + 4);

        chk("drain_fft", 32'(q_fft.size()), 32'd0);
        chk("drain_dma", 32'(q_dma.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
